whack_input_receiver: RTL and testbench
=======================================

# whack_input_receiver

Receive side of the mole/whack interface in the whack-a-mole game. Synchronizes and debounces the 16 player switches and turns each settled toggle into a hit or miss event against the current mole LED pattern. Events are buffered per switch and delivered one at a time over a valid/ready handshake to the scoring and mole logic. Keeps saturating hit and miss totals for the post-game display.

## Interface
- DEBOUNCE_CYCLES, 1_000_000, clock cycles between debounce sample ticks (10 ms at 100 MHz); legal range ≥2.
- TICK_W, 20, width of the tick counter; must hold DEBOUNCE_CYCLES-1.
- clock_i  in  1  system clock, single clock domain.
- reset_i  in  1  reset, synchronous, active-low.
- switches_i  in  16  raw asynchronous slide switches.
- moles_i  in  16  current mole LED pattern (1 = mole up), synchronous to clock_i.
- enable_i  in  1  game in progress; events are captured only while high.
- event_valid_o  out  1  an event is presented.
- event_ready_i  in  1  consumer accepts the event.
- event_index_o  out  4  switch number of the presented event.
- event_hit_o  out  1  1 = mole was up at that switch, 0 = miss.
- hits_o  out  16  accepted hit total, saturating.
- misses_o  out  16  accepted miss total, saturating.

## Operation
- Sync: two flops per switch (sync1, sync2); only sync2 is used downstream.
- Tick: a free-running counter counts 0..DEBOUNCE_CYCLES-1 and asserts tick for one cycle at terminal count, then wraps to 0.
- Debounce: on tick, samp <= sync2; db[i] <= sync2[i] only where sync2[i] == samp[i]. A level must therefore match on two consecutive ticks to settle.
- Prime: the first tick after reset loads samp and db directly from sync2 and raises primed. No edges are generated on that tick, so switches already up at reset produce no events.
- Edge: on each cycle, chg = db_next ^ db while primed.
  - A toggle in either direction counts as a whack.
  - If enable_i is high, pend |= chg.
  - If enable_i is low, pend is cleared to 0 and chg is discarded.
- Arbiter, a two-state machine:
  - IDLE: if pend != 0, pick the lowest set index i. Load event_index_o = i and event_hit_o = moles_i[i], sampled in this cycle. Clear pend[i]. Go to PRESENT.
  - PRESENT: event_valid_o = 1; index and hit are held stable. On event_ready_i = 1, add 1 to hits_o or misses_o (hold at 0xFFFF), deassert valid and go to IDLE.
- Merge: further toggles of a switch whose pend bit is already set merge into one event.
- Simultaneous set and clear: if switch i toggles in the same cycle its pend bit is cleared by the arbiter, pend[i] ends set (the new event is kept).
- enable_i falling while in PRESENT: the presented event stays until it is accepted, and its counters update normally.
- Reset mid-operation: every state returns to its reset value on the next edge. Any presented event is dropped without updating the counters.
- Reset values:
  - event_valid_o = 0, event_index_o = 0, event_hit_o = 0, hits_o = 0, misses_o = 0.
  - pend = 0, db = 0, samp = 0, primed = 0, tick counter = 0, state = IDLE.

## Timing
- Raw switch to sync2: 2 cycles.
- sync2 change to db change: between DEBOUNCE_CYCLES+1 and 2·DEBOUNCE_CYCLES cycles, depending on tick phase.
- db change to pend bit set: same edge (registered together). pend to event_valid_o high: 1 cycle (IDLE to PRESENT).
- Accept: the edge where valid and ready are both 1. Counters are updated on that edge, and valid is low the following cycle.
- Back-to-back events: at most one event every 2 cycles, since IDLE always occupies at least one cycle.
- event_ready_i while valid is low is ignored.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset with switches_i = 16'h0005 and enable_i = 1, then hold for 20 cycles -> event_valid_o stays 0, hits_o = misses_o = 0.
- Set moles_i = 16'h0008, raise switch 3, hold event_ready_i = 1 -> event_valid_o pulses once with index 3 and hit 1; hits_o = 1.
- Chatter on switch 7: toggle every cycle for 6 cycles, then settle high -> exactly one event, index 7, hit 0, misses_o = 1.
- Toggle switches 9 and 2 on the same cycle, with ready low for 10 cycles and then high -> index 2 is presented and held for the 10 cycles; index 9 follows, presented 2 cycles after index 2 is accepted.
- Toggle switch 4 with enable_i = 0 -> no event and pend stays 0. Then raise enable_i -> still no event for the earlier toggle.
- Preload misses_o to 16'hFFFE via 2 fewer accepted misses, then 3 more misses -> misses_o ends at 16'hFFFF. Assert reset_i = 0 while event_valid_o = 1 -> the next cycle shows valid 0 and both counters 0.

Source files
------------

// File: rtl/whack_input_receiver.sv
// whack_input_receiver: debounces 16 switches into hit/miss events over valid/ready with saturating totals
module whack_input_receiver #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_W = 20
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [15:0] switches_i,
  input  logic [15:0] moles_i,
  input  logic        enable_i,
  output logic        event_valid_o,
  input  logic        event_ready_i,
  output logic [3:0]  event_index_o,
  output logic        event_hit_o,
  output logic [15:0] hits_o,
  output logic [15:0] misses_o
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state, state_next;
  logic [15:0] sync1, sync2, samp, db, db_next, pend, pend_next, chg, clr;
  logic [TICK_W-1:0] tick_cnt;
  logic [3:0] pick;
  logic tick, primed, take, accept;
  always_ff @(posedge clock_i) begin
    sync1 <= switches_i;
    sync2 <= sync1;
  end
  assign tick = tick_cnt == TICK_W'(DEBOUNCE_CYCLES - 1);
  // A bit settles only when two consecutive tick samples agree
  assign db_next = !tick ? db : !primed ? sync2 : (db & (sync2 ^ samp)) | (sync2 & ~(sync2 ^ samp));
  assign chg = primed ? db_next ^ db : '0;
  always_comb begin
    pick = '0;
    for (int i = 15; i >= 0; i--) if (pend[i]) pick = 4'(i);
  end
  assign take = state == IDLE && pend != '0;
  assign accept = state == PRESENT && event_ready_i;
  assign clr = take ? 16'(1) << pick : '0;
  // A toggle landing on the cycle its bit is taken survives as a new event
  assign pend_next = enable_i ? (pend & ~clr) | chg : '0;
  always_comb state_next = take ? PRESENT : accept ? IDLE : state;
  assign event_valid_o = state == PRESENT;
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state <= IDLE;
      tick_cnt <= '0;
      samp <= '0;
      db <= '0;
      primed <= 1'b0;
      pend <= '0;
      event_index_o <= '0;
      event_hit_o <= 1'b0;
      hits_o <= '0;
      misses_o <= '0;
    end else begin
      state <= state_next;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) samp <= sync2;
      if (tick) primed <= 1'b1;
      db <= db_next;
      pend <= pend_next;
      if (take) event_index_o <= pick;
      if (take) event_hit_o <= moles_i[pick];
      if (accept && event_hit_o && hits_o != '1) hits_o <= hits_o + 1'b1;
      if (accept && !event_hit_o && misses_o != '1) misses_o <= misses_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_whack_input_receiver.sv
// tb_whack_input_receiver: directed checks of debounce, arbitration, handshake and saturation
module tb_whack_input_receiver;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset_n, enable, ready, valid, hit;
  logic [15:0] switches, moles, hits, misses;
  logic [3:0]  idx;
  int total = 0;
  int bad = 0;
  int ev;
  logic [3:0] last_idx;
  logic last_hit;
  logic [3:0] exp_idx [3] = '{4'd0, 4'd1, 4'd5};

  whack_input_receiver #(.DEBOUNCE_CYCLES(4), .TICK_W(2)) dut (
    .clock_i(clk), .reset_i(reset_n), .switches_i(switches), .moles_i(moles),
    .enable_i(enable), .event_valid_o(valid), .event_ready_i(ready),
    .event_index_o(idx), .event_hit_o(hit), .hits_o(hits), .misses_o(misses)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (valid !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    check(tag, 16'(valid), 16'd1);
  endtask

  task automatic watch(input int n);
    ev = 0;
    repeat (n) begin
      step();
      if (valid === 1'b1) begin
        ev++;
        last_idx = idx;
        last_hit = hit;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; ready = 1'b0; moles = '0; switches = 16'h0005;
    step(3);
    check("rst_valid", 16'(valid), 16'd0);
    check("rst_index", 16'(idx), 16'd0);
    check("rst_hit", 16'(hit), 16'd0);
    check("rst_hits", hits, 16'd0);
    check("rst_misses", misses, 16'd0);
    reset_n = 1'b1;
    watch(20);
    check("preset_switch_events", 16'(ev), 16'd0);
    check("preset_hits", hits, 16'd0);
    check("preset_misses", misses, 16'd0);

    moles = 16'h0008; ready = 1'b1; switches = 16'h000D;
    wait_valid("hit3_valid");
    check("hit3_index", 16'(idx), 16'd3);
    check("hit3_hit", 16'(hit), 16'd1);
    step();
    check("hit3_valid_drop", 16'(valid), 16'd0);
    check("hit3_hits", hits, 16'd1);
    watch(20);
    check("hit3_single_pulse", 16'(ev), 16'd0);

    repeat (6) begin
      switches = switches ^ 16'h0080;
      step();
    end
    switches[7] = 1'b1;
    watch(40);
    check("chatter7_events", 16'(ev), 16'd1);
    check("chatter7_index", 16'(last_idx), 16'd7);
    check("chatter7_hit", 16'(last_hit), 16'd0);
    check("chatter7_misses", misses, 16'd1);
    check("chatter7_hits", hits, 16'd1);

    ready = 1'b0;
    switches = switches ^ 16'h0204;
    wait_valid("pair_valid");
    repeat (10) begin
      check("pair_hold_valid", 16'(valid), 16'd1);
      check("pair_hold_index2", 16'(idx), 16'd2);
      step();
    end
    ready = 1'b1;
    step();
    check("pair_accept2_valid", 16'(valid), 16'd0);
    check("pair_accept2_misses", misses, 16'd2);
    step();
    check("pair_next_valid", 16'(valid), 16'd1);
    check("pair_next_index9", 16'(idx), 16'd9);
    check("pair_next_hit", 16'(hit), 16'd0);
    step();
    check("pair_accept9_valid", 16'(valid), 16'd0);
    check("pair_accept9_misses", misses, 16'd3);

    enable = 1'b0;
    switches = switches ^ 16'h0010;
    watch(20);
    check("disabled_events", 16'(ev), 16'd0);
    check("disabled_pend", dut.pend, 16'd0);
    enable = 1'b1;
    watch(20);
    check("reenabled_events", 16'(ev), 16'd0);
    check("reenabled_pend", dut.pend, 16'd0);
    check("reenabled_misses", misses, 16'd3);

    force dut.misses_o = 16'hFFFE;
    step();
    release dut.misses_o;
    step();
    check("preload_misses", misses, 16'hFFFE);
    switches = switches ^ 16'h0023;
    for (int i = 0; i < 3; i++) begin
      wait_valid("sat_valid");
      check("sat_index", 16'(idx), 16'(exp_idx[i]));
      step();
      check("sat_misses", misses, 16'hFFFF);
    end
    check("sat_hits", hits, 16'd1);

    ready = 1'b0;
    switches = switches ^ 16'h1000;
    wait_valid("midreset_valid");
    check("midreset_index", 16'(idx), 16'd12);
    reset_n = 1'b0;
    step();
    check("midreset_valid_drop", 16'(valid), 16'd0);
    check("midreset_hits", hits, 16'd0);
    check("midreset_misses", misses, 16'd0);
    check("midreset_index_clr", 16'(idx), 16'd0);
    reset_n = 1'b1;
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
